// File: rtl/timer_pkg.sv
// Shared state/mode types and default sizing for the programmable tick timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } timer_mode_t;

    localparam int TIMER_WIDTH          = 27;
    localparam int TIMER_CNT_W          = 16;
    localparam int TIMER_DEFAULT_PERIOD = 10_000_000;

endpackage

// File: rtl/prog_timer_cycle_counter.sv
// Cycle counter for prog_timer: counts up while enabled, wraps to 0 on the
// terminal-count compare, with a synchronous clear that takes priority.
module cycle_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    // >= so that a period shortened while paused expires on the next run edge
    assign expire = (count >= terminal);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= expire ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Runtime-programmable tick generator (periodic / one-shot, pause, clear).
// Optional lap capture is enabled by defining PROG_TIMER_LAP_EN.
//
// state | meaning
// IDLE  | stopped, counter cleared, waiting for start
// RUN   | counting cycles, ticking on each period expiry
// PAUSE | counter held, start resumes from the held value
// DONE  | one-shot period expired, start re-arms
module prog_timer
    import timer_pkg::*;
#(
    parameter int WIDTH          = TIMER_WIDTH,
    parameter int DEFAULT_PERIOD = TIMER_DEFAULT_PERIOD,
    parameter int CNT_W          = TIMER_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
`ifdef PROG_TIMER_LAP_EN
    input  logic             lap,
    output logic [CNT_W-1:0] lap_ticks,
    output logic [WIDTH-1:0] lap_cycles,
`endif
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             running,
    output logic             done
);

    timer_state_t     state, state_next;
    timer_mode_t      mode_q;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] cycles;
    logic             expire;
    logic             run_expire;
    logic             arm;
    logic             cnt_en;
    logic             cnt_clr;

    // fresh run from IDLE/DONE restarts the count and re-samples mode
    assign arm        = start && !stop && (state == IDLE || state == DONE);
    assign run_expire = (state == RUN) && expire;
    assign cnt_en     = (state == RUN) && (expire || !stop);
    assign cnt_clr    = clear || arm;

    cycle_counter #(
        .WIDTH (WIDTH)
    ) u_cycle_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .terminal (period - WIDTH'(1)),
        .count    (cycles),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (stop) begin
                        state_next = PAUSE;
                    end else if (expire && mode_q == ONESHOT) begin
                        state_next = DONE;
                    end
                end
                IDLE, PAUSE, DONE: begin
                    if (start && !stop) begin
                        state_next = RUN;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            period     <= WIDTH'(DEFAULT_PERIOD);
            mode_q     <= PERIODIC;
            tick       <= 1'b0;
            tick_count <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            running <= (state_next == RUN);
            done    <= (state_next == DONE);
            tick    <= !clear && run_expire;
            if (clear) begin
                tick_count <= '0;
            end else if (run_expire) begin
                tick_count <= tick_count + CNT_W'(1);
            end
            if (!clear && arm) begin
                mode_q <= timer_mode_t'(mode);
            end
            if (!clear && load && state != RUN) begin
                period <= (period_in == '0) ? WIDTH'(1) : period_in;
            end
        end
    end

`ifdef PROG_TIMER_LAP_EN
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            lap_ticks  <= '0;
            lap_cycles <= '0;
        end else if (clear) begin
            lap_ticks  <= '0;
            lap_cycles <= '0;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            lap_ticks  <= tick_count;
            lap_cycles <= cycles;
        end
    end
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: directed scenarios plus random stimulus,
// expectations from a behavioural model, checked by an independent monitor.
`timescale 1ns/1ps
module tb_prog_timer;

    localparam int WIDTH          = 8;
    localparam int DEFAULT_PERIOD = 5;
    localparam int CNT_W          = 3;
    localparam int CNT_MOD        = 1 << CNT_W;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic             mode = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] period_in = '0;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic             running;
    logic             done;
`ifdef PROG_TIMER_LAP_EN
    logic             lap = 1'b0;
    logic [CNT_W-1:0] lap_ticks;
    logic [WIDTH-1:0] lap_cycles;
`endif

    typedef struct {
        int tick;
        int count;
        int running;
        int done;
        int lap_t;
        int lap_c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int m_state, m_cycles, m_period, m_oneshot, m_count, m_tick, m_lap_t, m_lap_c;

    always #5 clk = ~clk;

    prog_timer #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .mode       (mode),
        .load       (load),
        .period_in  (period_in),
`ifdef PROG_TIMER_LAP_EN
        .lap        (lap),
        .lap_ticks  (lap_ticks),
        .lap_cycles (lap_cycles),
`endif
        .tick       (tick),
        .tick_count (tick_count),
        .running    (running),
        .done       (done)
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state   = M_IDLE;
        m_cycles  = 0;
        m_period  = DEFAULT_PERIOD;
        m_oneshot = 0;
        m_count   = 0;
        m_tick    = 0;
        m_lap_t   = 0;
        m_lap_c   = 0;
    endfunction

    function automatic void model_step(int st, int sp, int cl, int md, int ld, int pin, int lp);
        int pre;
        if (cl != 0) begin
            m_state  = M_IDLE;
            m_cycles = 0;
            m_count  = 0;
            m_tick   = 0;
            m_lap_t  = 0;
            m_lap_c  = 0;
            return;
        end
        pre = m_state;
        if (lp != 0 && (pre == M_RUN || pre == M_PAUSE)) begin
            m_lap_t = m_count;
            m_lap_c = m_cycles;
        end
        m_tick = 0;
        if (pre == M_RUN) begin
            if (m_cycles >= m_period - 1) begin
                m_tick   = 1;
                m_cycles = 0;
                m_count  = (m_count + 1) % CNT_MOD;
                if (sp != 0) m_state = M_PAUSE;
                else if (m_oneshot != 0) m_state = M_DONE;
            end else if (sp != 0) begin
                m_state = M_PAUSE;
            end else begin
                m_cycles++;
            end
        end else if (st != 0 && sp == 0) begin
            m_state = M_RUN;
            if (pre != M_PAUSE) begin
                m_cycles  = 0;
                m_oneshot = md;
            end
        end
        if (ld != 0 && pre != M_RUN) m_period = (pin == 0) ? 1 : pin;
    endfunction

    // one clock of stimulus: drive on the falling edge, predict, queue expectation
    task automatic cyc(input int st, input int sp, input int cl, input int md,
                       input int ld, input int pin, input int lp);
        exp_t e;
        @(negedge clk);
        start     = (st != 0);
        stop      = (sp != 0);
        clear     = (cl != 0);
        mode      = (md != 0);
        load      = (ld != 0);
        period_in = WIDTH'(pin);
`ifdef PROG_TIMER_LAP_EN
        lap       = (lp != 0);
`endif
        model_step(st, sp, cl, md, ld, pin, lp);
        e.tick    = m_tick;
        e.count   = m_count;
        e.running = (m_state == M_RUN) ? 1 : 0;
        e.done    = (m_state == M_DONE) ? 1 : 0;
        e.lap_t   = m_lap_t;
        e.lap_c   = m_lap_c;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_tick"}, int'(tick), 0);
        check({tag, "_count"}, int'(tick_count), 0);
        check({tag, "_running"}, int'(running), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("tick", int'(tick), e.tick);
                check("tick_count", int'(tick_count), e.count);
                check("running", int'(running), e.running);
                check("done", int'(done), e.done);
`ifdef PROG_TIMER_LAP_EN
                check("lap_ticks", int'(lap_ticks), e.lap_t);
                check("lap_cycles", int'(lap_cycles), e.lap_c);
`endif
            end
        end
    end

    initial begin : stim
        int r, st, sp, cl, ld, pin, md, lp;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        n_rst = 1'b0;

        // periodic, period 5
        cyc(0, 0, 0, 0, 1, 5, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(16);
        // one-shot period 4, then re-arm
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        idle(8);
        cyc(1, 0, 0, 1, 0, 0, 0);
        idle(6);
        // pause at cycles=6 of period 10, resume
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 10, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(6);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(20);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(6);
        // load ignored while running; load 0 becomes 1
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1, 3, 0);
        idle(20);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(10);
        // clear on the expiry edge; start+stop together in IDLE
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        // shrink period while paused past the new terminal count
        cyc(0, 0, 0, 0, 1, 10, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(7);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        // lap at tick_count=2, cycles=1
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(9);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // async reset mid-count
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 6, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(8);
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        #1;
        check_zero("async_rst");
        sb.delete();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        n_rst = 1'b0;
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(99));
            st = 0; sp = 0; cl = 0; ld = 0; pin = 0;
            if (r < 3) begin
                cl = 1;
            end else if (r < 15) begin
                ld  = 1;
                pin = int'($urandom_range(12));
            end else begin
                st = ($urandom_range(5) == 0) ? 1 : 0;
                sp = ($urandom_range(9) == 0) ? 1 : 0;
            end
            md = int'($urandom_range(1));
            lp = ($urandom_range(7) == 0) ? 1 : 0;
            cyc(st, sp, cl, md, ld, pin, lp);
        end

        idle(1);
        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
Runtime-programmable tick generator; next generation of the stopwatch's fixed-threshold one-second timer.
Adds a loadable period, periodic and one-shot modes, pause/resume and clear controls, and a running tick count.
Sits between the control FSM (start/stop/clear buttons, already debounced) and the display/BCD counters, which consume `tick` and `tick_count`.

Parameters:
- WIDTH, 27, bit width of the cycle counter and period register.
- DEFAULT_PERIOD, 10_000_000, period loaded at reset, in clk cycles; must be >= 1 and < 2**WIDTH.
- CNT_W, 16, bit width of `tick_count`.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- n_rst  in  1  asynchronous, active-high reset (1 = reset).
- start  in  1  level-sampled start/resume request.
- stop  in  1  level-sampled pause request.
- clear  in  1  synchronous clear of count state.
- mode  in  1  0 = PERIODIC, 1 = ONESHOT; sampled on start from IDLE/DONE.
- load  in  1  write `period_in` into the period register.
- period_in  in  WIDTH  new period in cycles.
- tick  out  1  single-cycle pulse at each period expiry.
- tick_count  out  CNT_W  number of ticks since last clear/reset.
- running  out  1  high while state == RUN.
- done  out  1  high in DONE (one-shot expired).

Behaviour:
- Reset (n_rst=1, asynchronous): state=IDLE, cycles=0, period=DEFAULT_PERIOD, mode_q=PERIODIC, tick=0, tick_count=0, running=0, done=0.
- States and transitions:
  - IDLE -start-> RUN: mode_q<=mode, cycles<=0.
  - RUN -stop-> PAUSE: cycles held.
  - PAUSE -start-> RUN: cycles resume from held value; mode_q unchanged.
  - RUN -expiry & mode_q=ONESHOT-> DONE.
  - DONE -start-> RUN: cycles<=0, mode_q<=mode, done cleared.
  - Any state -clear-> IDLE.
- Priority per edge: reset > clear > stop > start > load. start and stop together: stop wins (RUN→PAUSE; IDLE/PAUSE/DONE unchanged).
- Counting: cycles increments only on edges where state==RUN. On an RUN edge with cycles==period-1:
  - tick<=1, cycles<=0, tick_count<=tick_count+1 (wraps modulo 2**CNT_W, no saturation).
  - Otherwise tick<=0.
- tick is registered and high for exactly one cycle. First tick is visible P cycles after the edge that sampled start from IDLE (P = period).
- Expiry coincident with stop: tick fires and tick_count increments; state then goes to PAUSE with cycles=0.
- clear: cycles=0, tick_count=0, done=0, tick=0, state=IDLE; period register retained. Clear on the same edge as an expiry suppresses that tick.
- load:
  - Accepted only when state != RUN; ignored in RUN (no queuing).
  - period_in==0 is stored as 1 (tick every cycle in RUN).
  - Load in PAUSE with held cycles >= new period-1: next RUN edge is treated as expiry.
- Comparison compares against period-1 in WIDTH bits; no out-of-width arithmetic.
- Outputs registered: running==(state==RUN), done==(state==DONE). No combinational path from inputs to outputs.
- Reset asserted mid-count aborts immediately; no tick is emitted.

Optional Feature:
- Macro: PROG_TIMER_LAP_EN.
- Defined:
  - Adds input `lap` (1 bit) and outputs `lap_ticks` (CNT_W) and `lap_cycles` (WIDTH); both outputs reset to 0.
  - On an edge with lap=1 and state in {RUN, PAUSE}, captures pre-edge tick_count and cycles.
  - lap is ignored in IDLE/DONE. Clear zeroes both lap registers.
- Undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Package timer_pkg:
  - `timer_state_t` enum {IDLE, RUN, PAUSE, DONE}.
  - `timer_mode_t` enum {PERIODIC, ONESHOT}.
  - Localparam defaults for WIDTH/CNT_W.
- Sub-module `cycle_counter`: WIDTH-bit counter with enable, sync clear, and terminal-count compare, producing `expire`.
- prog_timer owns the FSM, period register, tick_count and the optional lap logic.

Test Plan:
- Reset, load period_in=5, start, mode=0 → tick high after edges 5, 10, 15; tick_count=3 after edge 15; running=1 throughout.
- Period=4, mode=1, start → single tick after edge 4; done=1, running=0; cycles frozen. Start again → next tick 4 cycles later, done cleared.
- Period=10, start; stop at cycles=6 for 20 cycles; start → tick exactly 4 RUN cycles after resume; tick_count=1.
- Load during RUN (period=8, load period_in=3) → ignored, ticks stay 8 apart. Load period_in=0 in IDLE → start gives tick every cycle.
- Clear on the expiry edge → no tick, tick_count=0, state IDLE, period retained. Start+stop together in IDLE → stays IDLE.
- CNT_W=2, period=1, 5 cycles of RUN → tick_count sequence 1,2,3,0,1. Assert n_rst mid-count → all outputs 0 asynchronously. With PROG_TIMER_LAP_EN, lap at tick_count=2/cycles=1 → lap_ticks=2, lap_cycles=1.
